// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline encodings: MDU tracker states and E-stage forward-select codes.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StWb   = 2'b10
  } mdu_state_e;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdW   = 2'b01;
  localparam logic [1:0] FwdM   = 2'b10;
  localparam logic [1:0] FwdMdu = 2'b11;

endpackage

// File: rtl/hazard_scoreboard_mdu_tracker.sv
// Tracks one in-flight multiply/divide op: latency countdown, pending
// destination, and the deferred register-file writeback slot.
module mdu_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = $clog2(MDU_LAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mdu_start_i,
  input  logic [REG_AW-1:0] mdu_dst_i,
  input  logic              regwrite_w_i,
  output logic              busy_o,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] dst_o
);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_AW-1:0] dst_q;
  logic              busy_q;
  logic              wb_arm_q;

  // FSM with registered busy and writeback-armed flags; starts while busy are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dst_q    <= '0;
      busy_q   <= 1'b0;
      wb_arm_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mdu_start_i) begin
            state_q <= StRun;
            cnt_q   <= CNT_W'(MDU_LAT - 2);
            dst_q   <= mdu_dst_i;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (cnt_q == '0) begin
            state_q  <= StWb;
            wb_arm_q <= (dst_q != '0);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWb: begin
          // The pipeline W-stage write owns the port; hold until it is free.
          if ((dst_q == '0) || !regwrite_w_i) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            wb_arm_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          wb_arm_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign wb_en_o = wb_arm_q & ~regwrite_w_i;
  assign dst_o   = dst_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle multiply/divide unit:
// forwarding selects, load-use/branch/MDU stalls, and MDU writeback tracking.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = $clog2(MDU_LAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic [REG_AW-1:0] writereg_w,
  input  logic              memtoreg_e,
  input  logic              memtoreg_m,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              branch_d,
  input  logic              mdu_op_d,
  input  logic              mdu_start_e,
  input  logic [REG_AW-1:0] mdu_dst_e,
  output logic              forwarda_d,
  output logic              forwardb_d,
  output logic [1:0]        forwarda_e,
  output logic [1:0]        forwardb_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              mdu_busy,
  output logic              mdu_wb_en,
  output logic [REG_AW-1:0] mdu_wb_reg
);

  logic [REG_AW-1:0] pend_dst;

  mdu_tracker #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) u_mdu_tracker (
    .clk         (clk),
    .reset       (reset),
    .mdu_start_i (mdu_start_e),
    .mdu_dst_i   (mdu_dst_e),
    .regwrite_w_i(regwrite_w),
    .busy_o      (mdu_busy),
    .wb_en_o     (mdu_wb_en),
    .dst_o       (pend_dst)
  );

  assign mdu_wb_reg = pend_dst;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] wr_m,
                                         input logic rw_m,
                                         input logic [REG_AW-1:0] wr_w,
                                         input logic rw_w,
                                         input logic [REG_AW-1:0] wr_mdu,
                                         input logic mdu_en);
    logic [1:0] sel;
    sel = FwdRf;
    if (src != '0) begin
      if (rw_m && (wr_m == src))          sel = FwdM;
      else if (rw_w && (wr_w == src))     sel = FwdW;
      else if (mdu_en && (wr_mdu == src)) sel = FwdMdu;
    end
    return sel;
  endfunction

  logic lwstall, branchstall, rawstall, structstall;

  // Forwarding selects and stall sources, all combinational.
  always_comb begin
    forwarda_d = (rs_d != '0) && regwrite_m && (writereg_m == rs_d);
    forwardb_d = (rt_d != '0) && regwrite_m && (writereg_m == rt_d);
    forwarda_e = fwd_sel(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w,
                         pend_dst, mdu_wb_en);
    forwardb_e = fwd_sel(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w,
                         pend_dst, mdu_wb_en);

    lwstall = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));

    branchstall = branch_d &&
        ((regwrite_e && (writereg_e != '0) &&
          ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
         (memtoreg_m && (writereg_m != '0) &&
          ((writereg_m == rs_d) || (writereg_m == rt_d))));

    // busy covers exactly the RUN and WB states.
    rawstall = ((rs_d != '0) && ((mdu_busy && (pend_dst == rs_d)) ||
                                 (mdu_start_e && (mdu_dst_e == rs_d)))) ||
               ((rt_d != '0) && ((mdu_busy && (pend_dst == rt_d)) ||
                                 (mdu_start_e && (mdu_dst_e == rt_d))));

    structstall = mdu_op_d && (mdu_busy || mdu_start_e);

    stall_d = lwstall || branchstall || rawstall || structstall;
    stall_f = stall_d;
    flush_e = stall_d;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-specifier width; register 0 is hardwired zero.
REQ-002 Parameter MDU_LAT, default 32, multiply/divide unit latency in cycles; legal range is 2 to 255.
REQ-003 Parameter CNT_W, default $clog2(MDU_LAT), latency-counter width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rs_d, rt_d, rs_e, rt_e  in  REG_AW  source specifiers in the D and E stages.
REQ-007 writereg_e, writereg_m, writereg_w  in  REG_AW  destination specifiers in the E, M and W stages.
REQ-008 memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w, branch_d  in  1  pipeline control flags.
REQ-009 mdu_op_d  in  1  the D-stage instruction is a multiply/divide op.
REQ-010 mdu_start_e, mdu_dst_e  in  1, REG_AW  a multiply/divide op occupies E; mdu_dst_e is its destination.
REQ-011 forwarda_d, forwardb_d  out  1  D-stage forward from M.
REQ-012 forwarda_e, forwardb_e  out  2  E-stage forward select: 00 = regfile, 01 = W, 10 = M, 11 = MDU result.
REQ-013 stall_f, stall_d, flush_e  out  1  pipeline control outputs.
REQ-014 mdu_busy  out  1  asserted when state is not IDLE.
REQ-015 mdu_wb_en, mdu_wb_reg  out  1, REG_AW  MDU register-file write strobe and write address.

Function
REQ-016 Forwarding rules:
- Both D and E forwarding require a nonzero source specifier.
- forwarda_d/forwardb_d use the M-stage match only.
- E-stage priority is M (10), then W (01), then an mdu_wb_en write to mdu_wb_reg (11), else 00.
REQ-017 lwstall = memtoreg_e & rt_e nonzero & (rt_e==rs_d | rt_e==rt_d).
REQ-018 branchstall = branch_d & ((regwrite_e & writereg_e matches rs_d or rt_d) | (memtoreg_m & writereg_m matches rs_d or rt_d)); a zero destination never matches.
REQ-019 rawstall asserts when a nonzero rs_d or rt_d equals:
- the pending destination while state is RUN or WB, or
- mdu_dst_e while mdu_start_e is high.
REQ-020 structstall = mdu_op_d & (mdu_busy | mdu_start_e).
REQ-021 Stall outputs:
- stall_d = lwstall | branchstall | rawstall | structstall.
- stall_f and flush_e equal stall_d in the same cycle.
- All outputs except the FSM-derived ones are purely combinational, with no modelled delays.
REQ-022 The FSM has three states: IDLE, RUN and WB.
REQ-023 IDLE to RUN occurs on mdu_start_e; the counter loads MDU_LAT-2 and the pending destination is captured.
REQ-024 RUN decrements the counter each cycle and moves to WB in the cycle after the counter reads 0, giving exactly MDU_LAT cycles from start to first WB cycle.
REQ-025 In WB, mdu_wb_en = ~regwrite_w & (pending dst != 0), since the pipeline W write has priority; mdu_wb_reg = pending dst.
REQ-026 WB exits to IDLE after the cycle in which mdu_wb_en is high, or immediately if the pending destination is 0; WB holds while regwrite_w is high.
REQ-027 mdu_start_e while not IDLE cannot occur given REQ-020; if it does, the FSM ignores it.
REQ-028 mdu_wb_en is a registered function of state and pending destination, gated only by regwrite_w.

Reset
REQ-029 On reset, the FSM goes to IDLE, the counter and pending destination clear to 0, and mdu_busy and mdu_wb_en go low.
REQ-030 Reset during RUN or WB discards the in-flight result; no mdu_wb_en pulse follows reset.
REQ-031 Combinational outputs depend only on inputs and the reset state while reset is held.

Structure
REQ-032 The FSM state encoding (IDLE, RUN, WB) and the forward-select codes (00, 01, 10, 11) live in a shared pipeline package.
REQ-033 The FSM, counter and pending-destination register form one sub-module, mdu_tracker; the forwarding and stall logic stays in the parent module.

Verification
REQ-034 Load-use: memtoreg_e=1, rt_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1 in the same cycle; with rt_e=0 -> all three 0.
REQ-035 Forward priority: rs_e=5 with writereg_m=5/regwrite_m=1 and writereg_w=5/regwrite_w=1 -> forwarda_e=10; M deasserted -> 01; both deasserted with mdu_wb_en to reg 5 -> 11.
REQ-036 Latency: MDU_LAT=4, mdu_start_e with dst=9 at cycle 0 -> mdu_busy from cycle 1; WB entered at cycle 4; mdu_wb_en=1, mdu_wb_reg=9 at cycle 4; IDLE at cycle 5.
REQ-037 Writeback conflict: regwrite_w=1 for 3 cycles during WB -> mdu_wb_en stays 0 for those cycles, then pulses once; rs_d=9 stalls until the cycle after the pulse.
REQ-038 Structural hazard: mdu_op_d=1 while RUN -> stall_d=1 until IDLE; reset asserted mid-RUN -> mdu_busy=0 immediately and no later mdu_wb_en pulse.
